// File: rtl/dec_gray2bin.sv
// rtl/dec_gray2bin.sv - sequential MSB-first Gray-to-binary decoder with single-step checker
module dec_gray2bin #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin,
  output logic             step_err,
  output logic [7:0]       err_cnt
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] prev_gray;
  logic             prev_ok;
  logic [IW-1:0]    idx;
  logic [IW:0]      idx_up;
  logic             accept;
  logic             step_bad;

  assign accept   = in_valid & in_ready;
  assign idx_up   = {1'b0, idx} + (IW+1)'(1);
  // a legal Gray step flips exactly one bit; a repeated code is also flagged
  assign step_bad = prev_ok && ($countones(gray ^ prev_gray) != 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (idx == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      bin       <= '0;
      step_err  <= 1'b0;
      err_cnt   <= 8'd0;
      g_reg     <= '0;
      prev_gray <= '0;
      prev_ok   <= 1'b0;
      idx       <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        g_reg          <= gray;
        bin[WIDTH-1]   <= gray[WIDTH-1];
        idx            <= IW'(WIDTH-2);
        step_err       <= step_bad;
        prev_gray      <= gray;
        prev_ok        <= 1'b1;
        if (step_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (state == BUSY) begin
        bin[idx] <= bin[idx_up] ^ g_reg[idx];
        if (idx != '0) idx <= idx - IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dec_gray2bin.sv
// tb/tb_dec_gray2bin.sv - self-checking bench for dec_gray2bin
module tb_dec_gray2bin;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] gray = '0;
  logic         in_ready, out_valid, step_err;
  logic [W-1:0] bin;
  logic [7:0]   err_cnt;

  dec_gray2bin #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .gray(gray), .out_valid(out_valid), .out_ready(out_ready),
    .bin(bin), .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_acc = 0;
  int prev_acc = 0;
  logic [W-1:0] last_out_bin = '0;
  logic         last_out_err = 1'b0;
  logic [7:0]   last_out_cnt = 8'd0;
  logic         rnd_ready = 1'b0;

  typedef struct {
    logic [W-1:0] b;
    logic         e;
    logic [7:0]   c;
    int           acc;
  } exp_t;
  exp_t q[$];

  logic [W-1:0] m_prev = '0;
  logic         m_prev_ok = 1'b0;
  int           m_cnt = 0;
  logic         first_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // binary bit i is the XOR of all Gray bits at or above i
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // compare process: model predicts each accept, checks every valid output cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      m_prev = '0;
      m_prev_ok = 1'b0;
      m_cnt = 0;
      first_seen = 1'b1;
    end else begin
      if (out_valid) begin
        check("ready_low_while_valid", in_ready, 0);
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          if (first_seen) begin
            check("latency", cycle - q[0].acc, W - 1);
            first_seen = 1'b0;
          end
          check("model_bin", bin, q[0].b);
          check("model_step_err", step_err, q[0].e);
          check("model_err_cnt", err_cnt, q[0].c);
          if (out_ready) begin
            last_out_bin = bin;
            last_out_err = step_err;
            last_out_cnt = err_cnt;
            void'(q.pop_front());
            first_seen = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t it;
        it.b = g2b(gray);
        it.e = m_prev_ok && ($countones(gray ^ m_prev) != 1);
        if (it.e && m_cnt < 255) m_cnt++;
        it.c = 8'(m_cnt);
        it.acc = cycle + 1;
        m_prev = gray;
        m_prev_ok = 1'b1;
        q.push_back(it);
        prev_acc = last_acc;
        last_acc = cycle + 1;
      end
    end
  end

  task automatic send(input logic [W-1:0] g);
    int n = 0;
    in_valid = 1'b1;
    gray = g;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    gray = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", 1, 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] sg[5] = '{10'h000, 10'h001, 10'h003, 10'h000, 10'h000};
  logic         se[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0]   sc[5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};

  initial begin
    int n;
    logic [W-1:0] pg;

    check("pin_3ff", g2b(10'h3FF), 10'h2AA);
    check("pin_200", g2b(10'h200), 10'h3FF);
    check("pin_155", g2b(10'h155), 10'h199);
    check("pin_003", g2b(10'h003), 10'h002);

    // reset with in_valid already high
    in_valid = 1'b1;
    gray = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bin", bin, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    check("first_cycle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("second_cycle_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ready_after_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_latency", n, W - 1);
    check("first_bin", bin, 10'h000);
    check("first_step_err", step_err, 0);
    check("first_err_cnt", err_cnt, 0);

    // back-to-back spacing with out_ready held high
    send(10'h3FF);
    send(10'h200);
    check("spacing_1", last_acc - prev_acc, W + 1);
    check("out_3ff", last_out_bin, 10'h2AA);
    send(10'h001);
    check("spacing_2", last_acc - prev_acc, W + 1);
    check("out_200", last_out_bin, 10'h3FF);
    wait_idle();
    check("out_001", last_out_bin, 10'h001);

    // step checker sequence from a fresh reset
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      send(sg[i]);
      wait_idle();
      check("step_seq_err", last_out_err, se[i]);
      check("step_seq_cnt", last_out_cnt, sc[i]);
    end

    // backpressure
    out_ready = 1'b0;
    send(10'h3FF);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_bin", bin, 10'h2AA);
      check("bp_step_err", step_err, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_err_cnt", err_cnt, 3);

    // reset mid-decode
    send(10'h001);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_bin", bin, 0);
    check("midrst_step_err", step_err, 0);
    check("midrst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abandoned_no_output", n, 0);
    send(10'h155);
    wait_idle();
    check("post_rst_bin", last_out_bin, 10'h199);
    check("post_rst_err", last_out_err, 0);

    // err_cnt saturation
    for (int i = 0; i < 260; i++) send((i % 2) ? 10'h003 : 10'h000);
    wait_idle();
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_last_bin", last_out_bin, 10'h002);

    // randomized words with random backpressure
    rnd_ready = 1'b1;
    pg = 10'h003;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) pg = pg ^ (W'(1) << $urandom_range(0, W - 1));
      else pg = W'($urandom);
      send(pg);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    wait_idle();
    @(posedge clk); #1;
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dec_gray2bin.md
# dec_gray2bin

Sequential Gray-to-binary decoder, the receive-side counterpart of `enc_bin2gray`. It accepts one WIDTH-bit Gray code word over a valid/ready handshake and resolves it MSB-first, one bit per clock, through a small FSM. It presents the binary result over a second valid/ready handshake. It also checks that each accepted code differs from the previously accepted code in exactly one bit, which is the legal step for a Gray counter crossing a clock domain, and counts violations.

## Interface
- WIDTH, 10, code width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  gray word offered
- in_ready  output  1  decoder can accept a word
- gray  input  WIDTH  Gray code word, sampled on the accept edge
- out_valid  output  1  bin/step_err valid
- out_ready  input  1  sink accepts result
- bin  output  WIDTH  decoded binary value
- step_err  output  1  accepted code was not a single-bit step from the previous accepted code
- err_cnt  output  8  saturating count of step errors since reset

## Operation
- FSM states: IDLE, BUSY, DONE.
- Accept = in_valid & in_ready, which is only possible in IDLE.
- On accept:
  - latch gray into g_reg; set bin[WIDTH-1] = gray[WIDTH-1]; set idx = WIDTH-2; go to BUSY.
  - evaluate the step check: step_err = prev_ok & (popcount(gray ^ prev_gray) != 1). Distance 0 (repeated code) is an error.
  - set prev_gray = gray and prev_ok = 1.
  - if the check fails and err_cnt < 255, increment err_cnt. err_cnt saturates at 255 and is cleared only by reset.
- BUSY, each edge: bin[idx] = bin[idx+1] ^ g_reg[idx]. If idx == 0, go to DONE; otherwise idx decrements.
- DONE: out_valid = 1. bin and step_err are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- in_ready is registered:
  - set to 1 on the edge entering IDLE and cleared on the accept edge.
  - reset value 0; it rises on the first edge after rst_n deasserts.
- gray is ignored outside the accept edge. Changes to in_valid or gray while busy have no effect.
- bin is intermediate (partially updated) during BUSY. Sinks must only sample it when out_valid is high.
- Reset (async, any state): state = IDLE, in_ready = 0, out_valid = 0, bin = 0, step_err = 0, err_cnt = 0, prev_gray = 0, prev_ok = 0, idx = 0.
- Reset mid-operation abandons the word in flight; no output is produced for it. The first code accepted after reset never flags step_err.

## Timing
- Accept on edge k.
- Bits WIDTH-2..0 resolve on edges k+1..k+WIDTH-1.
- out_valid rises after edge k+WIDTH-1. Latency is WIDTH-1 cycles (9 for WIDTH = 10).
- With out_ready held at 1:
  - the output handshake occurs on edge k+WIDTH;
  - in_ready rises after that edge;
  - the next accept is on edge k+WIDTH+1.
  - Sustained throughput is one word per WIDTH+1 cycles (11 for WIDTH = 10).
- Backpressure: while out_ready = 0 in DONE, out_valid, bin and step_err are held and in_ready stays 0. There is no input/output overlap.
- step_err is updated on the accept edge but is only qualified by out_valid. err_cnt updates on the accept edge and is always readable.
- No combinational path from any input to any output.

## Test plan
- Reset, then in_valid held at 1 with gray = 10'h000.
  - in_ready is 0 in the first cycle after reset, then 1.
  - After accept, out_valid appears exactly 9 cycles later with bin = 10'h000, step_err = 0, err_cnt = 0.
- Decode values with out_ready held at 1, checking the accept-to-accept spacing is 11 cycles:
  - gray 10'h3FF → bin 10'h2AA.
  - gray 10'h200 → bin 10'h3FF.
  - gray 10'h001 → bin 10'h001.
- Step check sequence (each word accepted in turn): 10'h000, 10'h001, 10'h003, 10'h000, 10'h000.
  - step_err = 0, 0, 0, 1, 1.
  - err_cnt = 0, 0, 0, 1, 2.
- Backpressure on a result of bin = 10'h2AA: hold out_ready = 0 for 5 cycles.
  - out_valid, bin and step_err stay stable; in_ready stays 0.
  - Raise out_ready: handshake on that edge, out_valid drops, in_ready rises next cycle.
- Assert rst_n = 0 mid-BUSY (after 4 bits resolved), then release.
  - All outputs read their reset values immediately; no out_valid occurs for the abandoned word.
  - Next word 10'h155 decodes to bin 10'h199 with step_err = 0.
- Feed 260 alternating 10'h000 / 10'h003 words (each is a two-bit step).
  - err_cnt saturates at 255 and stays there.
  - bin values remain correct throughout (10'h000 and 10'h002).
